cpu_sequencer: RTL and testbench

Clocked multi-cycle control FSM for the 8-bit CPU datapath. It steps the datapath through its eight phases, producing one-cycle enable strobes that drive the instruction memory, control unit, ALU, data memory, register-file writeback and PC update:

- **Phases:** fetch, decode, register read, execute, memory, writeback select, writeback, PC update.
- **Memory phase:** skipped for non-memory instructions; stalls on a data-memory ready handshake.
- **Halt:** on a zero instruction or stack-pointer underflow.
- **Counter:** counts retired instructions.

---
 rtl/cpu_seq_pkg.sv | 63 ++++++
 rtl/mem_wait_timer.sv | 31 +++
 rtl/cpu_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the cpu_sequencer control FSM.
// The PAUSE state exists only when SEQ_SINGLE_STEP_EN is defined.
package cpu_seq_pkg;

  localparam int unsigned DATA_W              = 8;
  localparam int unsigned PHASE_W             = 3;
  localparam int unsigned CNT_W               = 16;
  localparam int unsigned TIMER_W             = 8;
  localparam logic [DATA_W-1:0] SP_LIMIT_DEFAULT = 8'h7F;
  localparam int unsigned MEM_TIMEOUT_DEFAULT = 15;

  localparam logic [3:0] OP_JAL = 4'b1001;
  localparam logic [3:0] OP_LW  = 4'b1010;
  localparam logic [3:0] OP_SW  = 4'b1011;
  localparam logic [3:0] OP_BEQ = 4'b1100;
  localparam logic [3:0] OP_BNE = 4'b1101;

  localparam logic [PHASE_W-1:0] PH_FETCH   = 3'b000;
  localparam logic [PHASE_W-1:0] PH_DECODE  = 3'b001;
  localparam logic [PHASE_W-1:0] PH_REGREAD = 3'b010;
  localparam logic [PHASE_W-1:0] PH_EXEC    = 3'b011;
  localparam logic [PHASE_W-1:0] PH_MEM     = 3'b100;
  localparam logic [PHASE_W-1:0] PH_WBSEL   = 3'b101;
  localparam logic [PHASE_W-1:0] PH_WB      = 3'b110;
  localparam logic [PHASE_W-1:0] PH_PCUPD   = 3'b111;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_REGREAD,
    ST_EXEC,
    ST_MEM,
    ST_WBSEL,
    ST_WB,
    ST_PCUPD,
    ST_HALT
`ifdef SEQ_SINGLE_STEP_EN
    , ST_PAUSE
`endif
  } state_e;

  // Phase code presented on the phase port; IDLE/HALT read as 000.
  function automatic logic [PHASE_W-1:0] phase_of(input state_e s);
    logic [PHASE_W-1:0] ph;
    ph = PH_FETCH;
    case (s)
      ST_DECODE:  ph = PH_DECODE;
      ST_REGREAD: ph = PH_REGREAD;
      ST_EXEC:    ph = PH_EXEC;
      ST_MEM:     ph = PH_MEM;
      ST_WBSEL:   ph = PH_WBSEL;
      ST_WB:      ph = PH_WB;
      ST_PCUPD:   ph = PH_PCUPD;
`ifdef SEQ_SINGLE_STEP_EN
      ST_PAUSE:   ph = PH_PCUPD;
`endif
      default:    ph = PH_FETCH;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on data memory; expired_c flags the last
// allowed waiting cycle so the FSM can fault on the following edge.
module mem_wait_timer
  import cpu_seq_pkg::*;
#(
  parameter int unsigned LIMIT = MEM_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(LIMIT - 1);

  logic [TIMER_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && !expired_c) begin
      count_q <= count_q + TIMER_W'(1);
    end
  end

  assign expired_c = (count_q >= LAST);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM stepping the 8-bit CPU datapath through its phases.
// Optional single-step support (step_mode/step, PAUSE) under SEQ_SINGLE_STEP_EN.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter logic [DATA_W-1:0] SP_LIMIT    = SP_LIMIT_DEFAULT,
  parameter int unsigned       MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DATA_W-1:0]  instruction,
  input  logic [DATA_W-1:0]  sp,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic               reg_w_en,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic               step_mode,
  input  logic               step,
`endif
  input  logic               mem_ready,
  output logic               fetch_en,
  output logic               decode_en,
  output logic               regread_en,
  output logic               execute_en,
  output logic               wbsel_en,
  output logic               writeback_en,
  output logic               pc_en,
  output logic               mem_req,
  output logic [PHASE_W-1:0] phase,
  output logic               busy,
  output logic               halted,
  output logic               fault,
  output logic [CNT_W-1:0]   instr_count
);

  state_e           state_q, state_d;
  logic             fault_q;
  logic [CNT_W-1:0] instr_count_q;

  logic halt_chk;
  logic fault_set, fault_clr, retire;
  logic timer_clr, timer_en, timer_expired;

  assign halt_chk = (instruction == 8'h00) || (sp < SP_LIMIT);

  mem_wait_timer #(
    .LIMIT (MEM_TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (timer_clr),
    .en        (timer_en),
    .expired_c (timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and phase strobes, decoded from the registered state.
  always_comb begin
    state_d      = state_q;
    fetch_en     = 1'b0;
    decode_en    = 1'b0;
    regread_en   = 1'b0;
    execute_en   = 1'b0;
    wbsel_en     = 1'b0;
    writeback_en = 1'b0;
    pc_en        = 1'b0;
    mem_req      = 1'b0;
    fault_set    = 1'b0;
    fault_clr    = 1'b0;
    retire       = 1'b0;
    timer_clr    = 1'b1;
    timer_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_FETCH;
          fault_clr = 1'b1;
        end
      end
      ST_FETCH: begin
        fetch_en = 1'b1;
        state_d  = ST_DECODE;
      end
      ST_DECODE: begin
        if (halt_chk) begin
          state_d = ST_HALT;
        end else begin
          decode_en = 1'b1;
          state_d   = ST_REGREAD;
        end
      end
      ST_REGREAD: begin
        regread_en = 1'b1;
        state_d    = ST_EXEC;
      end
      ST_EXEC: begin
        execute_en = 1'b1;
        state_d    = (mem_r_en || mem_w_en) ? ST_MEM : ST_WBSEL;
      end
      ST_MEM: begin
        mem_req   = 1'b1;
        timer_clr = 1'b0;
        if (mem_ready) begin
          state_d = ST_WBSEL;
        end else if (timer_expired) begin
          state_d   = ST_HALT;
          fault_set = 1'b1;
        end else begin
          timer_en = 1'b1;
        end
      end
      ST_WBSEL: begin
        wbsel_en = 1'b1;
        state_d  = ST_WB;
      end
      ST_WB: begin
        writeback_en = reg_w_en;
        state_d      = ST_PCUPD;
      end
      ST_PCUPD: begin
        pc_en  = 1'b1;
        retire = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
        state_d = step_mode ? ST_PAUSE : ST_FETCH;
`else
        state_d = ST_FETCH;
`endif
      end
      ST_HALT: begin
        if (start) begin
          state_d   = ST_FETCH;
          fault_clr = 1'b1;
        end
      end
`ifdef SEQ_SINGLE_STEP_EN
      ST_PAUSE: begin
        if (step) begin
          state_d = ST_FETCH;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky memory-timeout flag, cleared only by a restart or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (fault_set) begin
      fault_q <= 1'b1;
    end else if (fault_clr) begin
      fault_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count_q <= '0;
    end else if (retire) begin
      instr_count_q <= instr_count_q + CNT_W'(1);
    end
  end

  always_comb begin
    phase  = phase_of(state_q);
    halted = (state_q == ST_HALT);
    busy   = (state_q != ST_IDLE) && (state_q != ST_HALT);
  end

  assign fault       = fault_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer (default MEM_TIMEOUT=15, SP_LIMIT=8'h7F).
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  instruction;
  logic [7:0]  sp;
  logic        mem_r_en, mem_w_en, reg_w_en, mem_ready;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step_mode, step;
`endif
  logic        fetch_en, decode_en, regread_en, execute_en;
  logic        wbsel_en, writeback_en, pc_en, mem_req;
  logic [2:0]  phase;
  logic        busy, halted, fault;
  logic [15:0] instr_count;
  logic [7:0]  obs_vec;

  int unsigned checks = 0;
  int unsigned errors = 0;

  cpu_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .instruction  (instruction),
    .sp           (sp),
    .mem_r_en     (mem_r_en),
    .mem_w_en     (mem_w_en),
    .reg_w_en     (reg_w_en),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode    (step_mode),
    .step         (step),
`endif
    .mem_ready    (mem_ready),
    .fetch_en     (fetch_en),
    .decode_en    (decode_en),
    .regread_en   (regread_en),
    .execute_en   (execute_en),
    .wbsel_en     (wbsel_en),
    .writeback_en (writeback_en),
    .pc_en        (pc_en),
    .mem_req      (mem_req),
    .phase        (phase),
    .busy         (busy),
    .halted       (halted),
    .fault        (fault),
    .instr_count  (instr_count)
  );

  always #5 clk = ~clk;

  // Strobe order: fetch, decode, regread, execute, mem_req, wbsel, writeback, pc.
  assign obs_vec = {fetch_en, decode_en, regread_en, execute_en,
                    mem_req, wbsel_en, writeback_en, pc_en};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag, input logic [7:0] ev, input logic [2:0] ep);
    #1;
    check({tag, " strobes"}, 32'(obs_vec), 32'(ev));
    check({tag, " phase"}, 32'(phase), 32'(ep));
    tick();
  endtask

  task automatic status(input string tag, input logic b, input logic h,
                        input logic f, input logic [15:0] cnt);
    #1;
    check({tag, " busy"}, 32'(busy), 32'(b));
    check({tag, " halted"}, 32'(halted), 32'(h));
    check({tag, " fault"}, 32'(fault), 32'(f));
    check({tag, " count"}, 32'(instr_count), 32'(cnt));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic front(input string tag);
    cyc({tag, " fetch"}, 8'h80, 3'd0);
    cyc({tag, " decode"}, 8'h40, 3'd1);
    cyc({tag, " regread"}, 8'h20, 3'd2);
    cyc({tag, " exec"}, 8'h10, 3'd3);
  endtask

  task automatic back(input string tag, input logic wb);
    cyc({tag, " wbsel"}, 8'h04, 3'd5);
    cyc({tag, " wb"}, wb ? 8'h02 : 8'h00, 3'd6);
    cyc({tag, " pcupd"}, 8'h01, 3'd7);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; instruction = 8'h41; sp = 8'hFF;
    mem_r_en = 1'b0; mem_w_en = 1'b0; reg_w_en = 1'b0; mem_ready = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    step_mode = 1'b0; step = 1'b0;
`endif
    #2;
    status("reset", 1'b0, 1'b0, 1'b0, 16'h0000);
    check("reset strobes", 32'(obs_vec), 32'h0);
    check("reset phase", 32'(phase), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    status("idle", 1'b0, 1'b0, 1'b0, 16'h0000);

    // ALU instruction: seven phases, no memory access
    reg_w_en = 1'b1;
    pulse_start();
    front("alu");
    back("alu", 1'b1);
    status("alu retired", 1'b1, 1'b0, 1'b0, 16'h0001);

    // Memory read stalled for three cycles
    mem_r_en = 1'b1;
    front("stall");
    for (int i = 0; i < 3; i++) cyc("stall mem wait", 8'h08, 3'd4);
    mem_ready = 1'b1;
    cyc("stall mem ready", 8'h08, 3'd4);
    mem_ready = 1'b0;
    mem_r_en  = 1'b0;
    back("stall", 1'b1);
    status("stall retired", 1'b1, 1'b0, 1'b0, 16'h0002);

    // Memory ready already high on entry: single MEM cycle
    mem_r_en  = 1'b1;
    mem_ready = 1'b1;
    front("nowait");
    cyc("nowait mem", 8'h08, 3'd4);
    mem_ready = 1'b0;
    mem_r_en  = 1'b0;
    back("nowait", 1'b1);
    status("nowait retired", 1'b1, 1'b0, 1'b0, 16'h0003);

    // Memory write that never completes
    mem_w_en = 1'b1;
    reg_w_en = 1'b0;
    front("timeout");
    for (int i = 0; i < 15; i++) cyc("timeout mem wait", 8'h08, 3'd4);
    status("timeout", 1'b0, 1'b1, 1'b1, 16'h0003);
    cyc("timeout halt", 8'h00, 3'd0);
    mem_w_en = 1'b0;
    reg_w_en = 1'b1;
    pulse_start();
    status("restart", 1'b1, 1'b0, 1'b0, 16'h0003);

    // Zero instruction halts from DECODE without decode_en
    instruction = 8'h00;
    cyc("zero fetch", 8'h80, 3'd0);
    cyc("zero decode", 8'h00, 3'd1);
    status("zero halt", 1'b0, 1'b1, 1'b0, 16'h0003);

    // Stack pointer one below the limit halts
    instruction = 8'h41;
    sp = 8'h7E;
    pulse_start();
    cyc("sp fetch", 8'h80, 3'd0);
    cyc("sp decode", 8'h00, 3'd1);
    status("sp halt", 1'b0, 1'b1, 1'b0, 16'h0003);

    // sp at the limit runs; later sp drop and start do not disturb it
    sp = 8'h7F;
    pulse_start();
    cyc("edge fetch", 8'h80, 3'd0);
    cyc("edge decode", 8'h40, 3'd1);
    sp = 8'h00;
    start = 1'b1;
    cyc("edge regread", 8'h20, 3'd2);
    start = 1'b0;
    cyc("edge exec", 8'h10, 3'd3);
    back("edge", 1'b1);
    status("edge retired", 1'b1, 1'b0, 1'b0, 16'h0004);
    cyc("edge2 fetch", 8'h80, 3'd0);
    cyc("edge2 decode", 8'h00, 3'd1);
    status("edge2 halt", 1'b0, 1'b1, 1'b0, 16'h0004);

    // Counter wrap from FFFF
    force dut.instr_count_q = 16'hFFFF;
    tick();
    release dut.instr_count_q;
    sp = 8'hFF;
    pulse_start();
    front("wrap");
    back("wrap", 1'b1);
    status("wrap", 1'b1, 1'b0, 1'b0, 16'h0000);

`ifdef SEQ_SINGLE_STEP_EN
    step_mode = 1'b1;
    front("step");
    back("step", 1'b1);
    cyc("step pause", 8'h00, 3'd7);
    cyc("step pause hold", 8'h00, 3'd7);
    status("step pause", 1'b1, 1'b0, 1'b0, 16'h0001);
    step_mode = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
`endif

    // Asynchronous reset in EXEC
    cyc("rst fetch", 8'h80, 3'd0);
    cyc("rst decode", 8'h40, 3'd1);
    mem_r_en = 1'b1;
    cyc("rst regread", 8'h20, 3'd2);
    #2;
    rst_n = 1'b0;
    status("mid reset", 1'b0, 1'b0, 1'b0, 16'h0000);
    check("mid reset strobes", 32'(obs_vec), 32'h0);
    check("mid reset phase", 32'(phase), 32'h0);
    mem_r_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    cyc("post reset fetch", 8'h80, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
